// File: rtl/output_io_bank.sv
`default_nettype none
// ============================================================================
// Module   : output_io_bank
// Purpose  : WIDTH-channel output I/O cell, buffered or registered mode with a
//            per-channel output-enable turnaround sequencer.
// Option   : OUTPUT_IO_BANK_READBACK_EN builds the registered pad readback F2A.
// Revision : 1.0 - initial release
// ============================================================================
module output_io_bank #(
    parameter int WIDTH    = 4,
    parameter     MODE     = "out_reg",
    parameter int TURN_CYC = 2
) (
    input  logic             IQC,
    input  logic             QRT,
    input  logic             IQCE,
    input  logic [WIDTH-1:0] OQI,
    input  logic [WIDTH-1:0] IE,
    output logic [WIDTH-1:0] PAD_O,
    output logic [WIDTH-1:0] PAD_OE,
    output logic [WIDTH-1:0] F2A,
    output logic             BUSY
);

    localparam logic [1:0] c_st_off  = 2'd0;
    localparam logic [1:0] c_st_turn = 2'd1;
    localparam logic [1:0] c_st_on   = 2'd2;
    localparam logic [3:0] c_turn    = 4'(TURN_CYC);

    generate
        if (MODE == "out_buff") begin : g_buff
            assign PAD_O  = OQI;
            assign PAD_OE = IE;
            assign BUSY   = 1'b0;

            // Clock, reset and enable only matter here when readback is built.
            logic w_unused;
            assign w_unused = &{1'b0, IQC, QRT, IQCE};
        end else begin : g_reg
            logic [WIDTH-1:0] r_d_q;
            logic [WIDTH-1:0] w_oe;
            logic [WIDTH-1:0] w_turn;

            always_ff @(posedge IQC) begin
                if (!QRT) begin
                    r_d_q <= '0;
                end else if (IQCE) begin
                    r_d_q <= OQI;
                end
            end

            for (genvar i = 0; i < WIDTH; i++) begin : g_ch
                logic [1:0] r_state;
                logic [1:0] w_state_nxt;
                logic [3:0] r_cnt;
                logic [3:0] w_cnt_nxt;
                logic       w_ch_oe;
                logic       w_ch_turn;

                always_ff @(posedge IQC) begin
                    if (!QRT) begin
                        r_state <= c_st_off;
                        r_cnt   <= 4'd0;
                    end else if (IQCE) begin
                        r_state <= w_state_nxt;
                        r_cnt   <= w_cnt_nxt;
                    end
                end

                always_comb begin
                    w_state_nxt = r_state;
                    w_cnt_nxt   = r_cnt;
                    case (r_state)
                        c_st_off: begin
                            if (IE[i]) begin
                                if (c_turn == 4'd0) begin
                                    w_state_nxt = c_st_on;
                                end else begin
                                    w_state_nxt = c_st_turn;
                                    w_cnt_nxt   = c_turn;
                                end
                            end
                        end
                        c_st_turn: begin
                            // Dropping the request mid-turnaround aborts without driving.
                            if (!IE[i]) begin
                                w_state_nxt = c_st_off;
                                w_cnt_nxt   = 4'd0;
                            end else if (r_cnt == 4'd1) begin
                                w_state_nxt = c_st_on;
                                w_cnt_nxt   = 4'd0;
                            end else begin
                                w_cnt_nxt   = r_cnt - 4'd1;
                            end
                        end
                        c_st_on: begin
                            if (!IE[i]) begin
                                w_state_nxt = c_st_off;
                            end
                        end
                        default: begin
                            w_state_nxt = c_st_off;
                            w_cnt_nxt   = 4'd0;
                        end
                    endcase
                end

                always_comb begin
                    w_ch_oe   = (r_state == c_st_on);
                    w_ch_turn = (r_state == c_st_turn);
                end

                assign w_oe[i]   = w_ch_oe;
                assign w_turn[i] = w_ch_turn;
            end

            assign PAD_O  = r_d_q;
            assign PAD_OE = w_oe;
            assign BUSY   = |w_turn;
        end
    endgenerate

`ifdef OUTPUT_IO_BANK_READBACK_EN
    logic [WIDTH-1:0] r_f2a;

    always_ff @(posedge IQC) begin
        if (!QRT) begin
            r_f2a <= '0;
        end else if (IQCE) begin
            r_f2a <= PAD_O & PAD_OE;
        end
    end

    assign F2A = r_f2a;
`else
    assign F2A = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_output_io_bank.sv
`default_nettype none
// Self-checking bench for output_io_bank: registered instances with TURN_CYC 1/2/3
// plus a buffered instance; expected rows are queued at drive time and popped after the edge.
module tb_output_io_bank;

`ifdef OUTPUT_IO_BANK_READBACK_EN
    localparam logic [3:0] RBM = 4'hF;
`else
    localparam logic [3:0] RBM = 4'h0;
`endif

    typedef struct packed {
        logic       qrt;
        logic       ce;
        logic [3:0] oqi;
        logic [3:0] ie;
        logic [3:0] pad_o;
        logic [3:0] pad_oe;
        logic       busy;
        logic       chk_f2a;
        logic [3:0] f2a;
    } row_t;

    logic       clk = 1'b0;
    logic       qrt;
    logic       ce;
    logic [3:0] oqi;
    logic [3:0] ie;

    logic [3:0] p1_o, p1_oe, f1, p2_o, p2_oe, f2, p3_o, p3_oe, f3, pb_o, pb_oe, fb;
    logic       b1, b2, b3, bb;

    int         sel;
    logic [3:0] o_pad_o, o_pad_oe, o_f2a;
    logic       o_busy;

    int   n_cmp  = 0;
    int   n_fail = 0;
    row_t sb[$];

    always #5 clk = ~clk;

    output_io_bank #(.WIDTH(4), .MODE("out_reg"), .TURN_CYC(1)) u_dut1 (
        .IQC(clk), .QRT(qrt), .IQCE(ce), .OQI(oqi), .IE(ie),
        .PAD_O(p1_o), .PAD_OE(p1_oe), .F2A(f1), .BUSY(b1));
    output_io_bank #(.WIDTH(4), .MODE("out_reg"), .TURN_CYC(2)) u_dut2 (
        .IQC(clk), .QRT(qrt), .IQCE(ce), .OQI(oqi), .IE(ie),
        .PAD_O(p2_o), .PAD_OE(p2_oe), .F2A(f2), .BUSY(b2));
    output_io_bank #(.WIDTH(4), .MODE("out_reg"), .TURN_CYC(3)) u_dut3 (
        .IQC(clk), .QRT(qrt), .IQCE(ce), .OQI(oqi), .IE(ie),
        .PAD_O(p3_o), .PAD_OE(p3_oe), .F2A(f3), .BUSY(b3));
    output_io_bank #(.WIDTH(4), .MODE("out_buff"), .TURN_CYC(2)) u_buf (
        .IQC(clk), .QRT(qrt), .IQCE(ce), .OQI(oqi), .IE(ie),
        .PAD_O(pb_o), .PAD_OE(pb_oe), .F2A(fb), .BUSY(bb));

    always_comb begin
        o_pad_o = p2_o; o_pad_oe = p2_oe; o_f2a = f2; o_busy = b2;
        case (sel)
            1: begin o_pad_o = p1_o; o_pad_oe = p1_oe; o_f2a = f1; o_busy = b1; end
            3: begin o_pad_o = p3_o; o_pad_oe = p3_oe; o_f2a = f3; o_busy = b3; end
            4: begin o_pad_o = pb_o; o_pad_oe = pb_oe; o_f2a = fb; o_busy = bb; end
            default: ;
        endcase
    end

    task automatic test_reset();
        row_t tbl [7];
        row_t e;
        sel = 2;
        tbl = '{'{1'b0,1'b1,4'hF,4'hF, 4'h0,4'h0,1'b0,1'b1,4'h0},
                '{1'b0,1'b1,4'hF,4'hF, 4'h0,4'h0,1'b0,1'b1,4'h0},
                '{1'b0,1'b1,4'hF,4'hF, 4'h0,4'h0,1'b0,1'b1,4'h0},
                '{1'b1,1'b1,4'hF,4'hF, 4'hF,4'h0,1'b1,1'b1,4'h0},
                '{1'b1,1'b1,4'hF,4'hF, 4'hF,4'h0,1'b1,1'b1,4'h0},
                '{1'b1,1'b1,4'hF,4'hF, 4'hF,4'hF,1'b0,1'b1,4'h0},
                '{1'b1,1'b1,4'hF,4'hF, 4'hF,4'hF,1'b0,1'b1,4'hF & RBM}};
        foreach (tbl[i]) begin
            qrt = tbl[i].qrt; ce = tbl[i].ce; oqi = tbl[i].oqi; ie = tbl[i].ie;
            sb.push_back(tbl[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++; if (o_pad_o !== e.pad_o) begin n_fail++; $display("FAIL reset pad_o row %0d: got %h want %h", i, o_pad_o, e.pad_o); end
            n_cmp++; if (o_pad_oe !== e.pad_oe) begin n_fail++; $display("FAIL reset pad_oe row %0d: got %h want %h", i, o_pad_oe, e.pad_oe); end
            n_cmp++; if (o_busy !== e.busy) begin n_fail++; $display("FAIL reset busy row %0d: got %b want %b", i, o_busy, e.busy); end
            if (e.chk_f2a) begin
                n_cmp++; if (o_f2a !== e.f2a) begin n_fail++; $display("FAIL reset f2a row %0d: got %h want %h", i, o_f2a, e.f2a); end
            end
        end
    endtask

    task automatic test_turnaround();
        row_t tbl [5];
        row_t e;
        sel = 2;
        tbl = '{'{1'b0,1'b1,4'h0,4'h0, 4'h0,4'h0,1'b0,1'b0,4'h0},
                '{1'b1,1'b1,4'hA,4'h1, 4'hA,4'h0,1'b1,1'b0,4'h0},
                '{1'b1,1'b1,4'hA,4'h1, 4'hA,4'h0,1'b1,1'b0,4'h0},
                '{1'b1,1'b1,4'hA,4'h1, 4'hA,4'h1,1'b0,1'b0,4'h0},
                '{1'b1,1'b1,4'hA,4'h0, 4'hA,4'h0,1'b0,1'b0,4'h0}};
        foreach (tbl[i]) begin
            qrt = tbl[i].qrt; ce = tbl[i].ce; oqi = tbl[i].oqi; ie = tbl[i].ie;
            sb.push_back(tbl[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++; if (o_pad_o !== e.pad_o) begin n_fail++; $display("FAIL turnaround pad_o row %0d: got %h want %h", i, o_pad_o, e.pad_o); end
            n_cmp++; if (o_pad_oe !== e.pad_oe) begin n_fail++; $display("FAIL turnaround pad_oe row %0d: got %h want %h", i, o_pad_oe, e.pad_oe); end
            n_cmp++; if (o_busy !== e.busy) begin n_fail++; $display("FAIL turnaround busy row %0d: got %b want %b", i, o_busy, e.busy); end
        end
    endtask

    task automatic test_abort();
        row_t tbl [5];
        row_t e;
        sel = 3;
        tbl = '{'{1'b0,1'b1,4'h0,4'h0, 4'h0,4'h0,1'b0,1'b0,4'h0},
                '{1'b1,1'b1,4'h0,4'h2, 4'h0,4'h0,1'b1,1'b0,4'h0},
                '{1'b1,1'b1,4'h0,4'h2, 4'h0,4'h0,1'b1,1'b0,4'h0},
                '{1'b1,1'b1,4'h0,4'h0, 4'h0,4'h0,1'b0,1'b0,4'h0},
                '{1'b1,1'b1,4'h0,4'h0, 4'h0,4'h0,1'b0,1'b0,4'h0}};
        foreach (tbl[i]) begin
            qrt = tbl[i].qrt; ce = tbl[i].ce; oqi = tbl[i].oqi; ie = tbl[i].ie;
            sb.push_back(tbl[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++; if (o_pad_oe !== e.pad_oe) begin n_fail++; $display("FAIL abort pad_oe row %0d: got %h want %h", i, o_pad_oe, e.pad_oe); end
            n_cmp++; if (o_busy !== e.busy) begin n_fail++; $display("FAIL abort busy row %0d: got %b want %b", i, o_busy, e.busy); end
        end
    endtask

    task automatic test_clock_enable();
        row_t tbl [10];
        row_t e;
        sel = 2;
        tbl = '{'{1'b0,1'b1,4'h0,4'h0, 4'h0,4'h0,1'b0,1'b0,4'h0},
                '{1'b1,1'b1,4'h5,4'h1, 4'h5,4'h0,1'b1,1'b0,4'h0},
                '{1'b1,1'b0,4'h3,4'h1, 4'h5,4'h0,1'b1,1'b0,4'h0},
                '{1'b1,1'b0,4'h3,4'h1, 4'h5,4'h0,1'b1,1'b0,4'h0},
                '{1'b1,1'b0,4'h3,4'h1, 4'h5,4'h0,1'b1,1'b0,4'h0},
                '{1'b1,1'b0,4'h3,4'h1, 4'h5,4'h0,1'b1,1'b0,4'h0},
                '{1'b1,1'b0,4'h3,4'h1, 4'h5,4'h0,1'b1,1'b0,4'h0},
                '{1'b1,1'b1,4'h3,4'h1, 4'h3,4'h0,1'b1,1'b0,4'h0},
                '{1'b1,1'b1,4'h3,4'h1, 4'h3,4'h1,1'b0,1'b0,4'h0},
                '{1'b0,1'b0,4'h3,4'h1, 4'h0,4'h0,1'b0,1'b0,4'h0}};
        foreach (tbl[i]) begin
            qrt = tbl[i].qrt; ce = tbl[i].ce; oqi = tbl[i].oqi; ie = tbl[i].ie;
            sb.push_back(tbl[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++; if (o_pad_o !== e.pad_o) begin n_fail++; $display("FAIL clock_enable pad_o row %0d: got %h want %h", i, o_pad_o, e.pad_o); end
            n_cmp++; if (o_pad_oe !== e.pad_oe) begin n_fail++; $display("FAIL clock_enable pad_oe row %0d: got %h want %h", i, o_pad_oe, e.pad_oe); end
            n_cmp++; if (o_busy !== e.busy) begin n_fail++; $display("FAIL clock_enable busy row %0d: got %b want %b", i, o_busy, e.busy); end
        end
        ce = 1'b1;
    endtask

    task automatic test_independent();
        row_t tbl [6];
        row_t e;
        sel = 1;
        tbl = '{'{1'b0,1'b1,4'h0,4'h0, 4'h0,4'h0,1'b0,1'b0,4'h0},
                '{1'b1,1'b1,4'h0,4'h1, 4'h0,4'h0,1'b1,1'b0,4'h0},
                '{1'b1,1'b1,4'h0,4'h9, 4'h0,4'h1,1'b1,1'b0,4'h0},
                '{1'b1,1'b1,4'h0,4'h9, 4'h0,4'h9,1'b0,1'b0,4'h0},
                '{1'b1,1'b1,4'h0,4'h8, 4'h0,4'h8,1'b0,1'b0,4'h0},
                '{1'b1,1'b1,4'h0,4'h8, 4'h0,4'h8,1'b0,1'b0,4'h0}};
        foreach (tbl[i]) begin
            qrt = tbl[i].qrt; ce = tbl[i].ce; oqi = tbl[i].oqi; ie = tbl[i].ie;
            sb.push_back(tbl[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++; if (o_pad_oe !== e.pad_oe) begin n_fail++; $display("FAIL independent pad_oe row %0d: got %h want %h", i, o_pad_oe, e.pad_oe); end
            n_cmp++; if (o_busy !== e.busy) begin n_fail++; $display("FAIL independent busy row %0d: got %b want %b", i, o_busy, e.busy); end
        end
    endtask

    task automatic test_readback();
        row_t tbl [7];
        row_t e;
        sel = 2;
        tbl = '{'{1'b0,1'b1,4'h0,4'h0, 4'h0,4'h0,1'b0,1'b1,4'h0},
                '{1'b1,1'b1,4'h4,4'h4, 4'h4,4'h0,1'b1,1'b1,4'h0},
                '{1'b1,1'b1,4'h4,4'h4, 4'h4,4'h0,1'b1,1'b1,4'h0},
                '{1'b1,1'b1,4'h4,4'h4, 4'h4,4'h4,1'b0,1'b1,4'h0},
                '{1'b1,1'b1,4'h4,4'h4, 4'h4,4'h4,1'b0,1'b1,4'h4 & RBM},
                '{1'b1,1'b1,4'h4,4'h0, 4'h4,4'h0,1'b0,1'b1,4'h4 & RBM},
                '{1'b1,1'b1,4'h4,4'h0, 4'h4,4'h0,1'b0,1'b1,4'h0}};
        foreach (tbl[i]) begin
            qrt = tbl[i].qrt; ce = tbl[i].ce; oqi = tbl[i].oqi; ie = tbl[i].ie;
            sb.push_back(tbl[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++; if (o_pad_oe !== e.pad_oe) begin n_fail++; $display("FAIL readback pad_oe row %0d: got %h want %h", i, o_pad_oe, e.pad_oe); end
            if (e.chk_f2a) begin
                n_cmp++; if (o_f2a !== e.f2a) begin n_fail++; $display("FAIL readback f2a row %0d: got %h want %h", i, o_f2a, e.f2a); end
            end
        end
    endtask

    task automatic test_buff();
        row_t e;
        logic [3:0] d;
        logic [3:0] en;
        sel = 4;
        qrt = 1'b1;
        d   = 4'($urandom);
        en  = 4'($urandom);
        for (int i = 0; i < 10; i++) begin
            #3;
            d  = ~d;
            en = ~en;
            ce = i[0];
            oqi = d; ie = en;
            sb.push_back('{1'b1, ce, d, en, d, en, 1'b0, 1'b0, 4'h0});
            #1;
            e = sb.pop_front();
            n_cmp++; if (o_pad_o !== e.pad_o) begin n_fail++; $display("FAIL buff pad_o step %0d: got %h want %h", i, o_pad_o, e.pad_o); end
            n_cmp++; if (o_pad_oe !== e.pad_oe) begin n_fail++; $display("FAIL buff pad_oe step %0d: got %h want %h", i, o_pad_oe, e.pad_oe); end
            n_cmp++; if (o_busy !== e.busy) begin n_fail++; $display("FAIL buff busy step %0d: got %b want %b", i, o_busy, e.busy); end
        end
        ce = 1'b1;
    endtask

    initial begin
        qrt = 1'b0; ce = 1'b1; oqi = 4'h0; ie = 4'h0; sel = 2;
        test_reset();
        test_turnaround();
        test_abort();
        test_clock_enable();
        test_independent();
        test_readback();
        test_buff();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
